// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions.
// Segment order is {a,b,c,d,e,f,g,dp}: bit 7 = a, bit 0 = dp.
// Patterns here are active-high; polarity is applied at the output pins.
package sseg_pkg;

    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_0    = 8'hFC;
    localparam logic [7:0] SEG_1    = 8'h60;
    localparam logic [7:0] SEG_2    = 8'hDA;
    localparam logic [7:0] SEG_3    = 8'hF2;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'hB6;
    localparam logic [7:0] SEG_6    = 8'hBE;
    localparam logic [7:0] SEG_7    = 8'hE0;
    localparam logic [7:0] SEG_8    = 8'hFE;
    localparam logic [7:0] SEG_9    = 8'hF6;
    localparam logic [7:0] SEG_DASH = 8'h02;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // One complete display image: four digits, their decimal points and the
    // leading-zero blanking enable that travels with them.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
    } disp_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational BCD to seven-segment decoder (active-high pattern).
// Ports:
//   bcd_i  - 4-bit digit; 0xA..0xF render as a dash (segment g)
//   dp_i   - decimal point, OR'd into bit 0
//   seg_o  - {a,b,c,d,e,f,g,dp} pattern
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] pat;

    always_comb begin
        pat = SEG_DASH;
        case (bcd_i)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        seg_o = pat;
        seg_o[SEG_DP_BIT] = pat[SEG_DP_BIT] | dp_i;
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Four-digit seven-segment scan multiplexer with blanking gap and
// frame-synchronous double buffering.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   digits_in   - four BCD nibbles, [3:0] is digit 0 (rightmost)
//   dp_in       - decimal point per digit
//   lz_blank    - leading-zero blanking enable, captured with digits_in
//   load        - strobe capturing the inputs into the pending buffer
//   pending     - captured image waiting for the next frame boundary
//   frame_tick  - pulse on each display-buffer update cycle
//   an, sseg    - registered anode and segment drives
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    input  logic        load,
    output logic        pending,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(DIGIT_CYCLES - 1);
    localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);
    localparam logic [3:0] AnOff  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] SegOff = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    disp_t           disp_q, disp_d;
    disp_t           pend_q, pend_d;
    logic            pending_q, pending_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      sseg_q, sseg_d;

    disp_t      in_img;
    logic       apply;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic [7:0] dec_pat;
    logic [7:0] pat;
    logic [3:0] lead_zero;
    logic [3:0] an_sel;

    assign in_img = '{digits: digits_in, dp: dp_in, lz: lz_blank};
    assign apply  = (cnt_q == '0) && (idx_q == 2'd0);

    // Slot counter, buffers and handshake.
    always_comb begin
        cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        idx_d     = (cnt_q == CntMax) ? idx_q + 2'd1 : idx_q;
        pend_d    = load ? in_img : pend_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (apply) begin
            // A load on the boundary itself goes straight to the display.
            if (load) begin
                disp_d = in_img;
            end else if (pending_q) begin
                disp_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Digit n is a leading zero if it and every higher digit are zero;
    // digit 0 always shows.
    always_comb begin
        lead_zero[3] = (disp_q.digits[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_q.digits[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_q.digits[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    assign cur_nib = disp_q.digits[{idx_q, 2'b00} +: 4];
    assign cur_dp  = disp_q.dp[idx_q];

    sseg_decode u_decode (
        .bcd_i (cur_nib),
        .dp_i  (cur_dp),
        .seg_o (dec_pat)
    );

    always_comb begin
        pat = dec_pat;
        if (disp_q.lz && lead_zero[idx_q]) begin
            pat = SEG_OFF;
            pat[SEG_DP_BIT] = cur_dp;
        end
        an_sel = 4'b0001 << idx_q;
        if (cnt_q < BlankCnt) begin
            an_d   = AnOff;
            sseg_d = SegOff;
        end else begin
            an_d   = AN_ACTIVE_LOW ? ~an_sel : an_sel;
            sseg_d = SEG_ACTIVE_LOW ? ~pat : pat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= AnOff;
            sseg_q    <= SegOff;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign pending = pending_q;
    // The boundary state is also the reset state, so mask it while reset is held.
    assign frame_tick = apply & ~rst;
    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux with DIGIT_CYCLES = 8, BLANK_CYCLES = 2.
// cyc counts rising edges since reset release; cycle 0 is the first boundary.
module tb_sseg_scan_mux;

    localparam int unsigned DC = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned FR = 4 * DC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic        pending;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] exp;  // expected sseg per digit, [0] = digit 0
    } vec_t;

    vec_t vecs [6];

    sseg_scan_mux #(
        .DIGIT_CYCLES   (DC),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load       (load),
        .pending    (pending),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        cyc = 0;
    endtask

    function automatic int next_frame();
        return ((cyc / FR) + 1) * FR;
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
        digits_in = d;
        dp_in     = p;
        lz_blank  = lz;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Check blank gap and lit digit for every slot of the frame starting at f.
    task automatic check_frame(input int f, input logic [3:0][7:0] exp, input string tag);
        logic [3:0] sel;
        for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            goto(f + d * DC + 1);
            check({tag, "_gap_an"}, {4'h0, an}, 8'h0F);
            check({tag, "_gap_sseg"}, sseg, 8'hFF);
            goto(f + d * DC + 4);
            check({tag, "_an"}, {4'h0, an}, {4'h0, sel});
            check({tag, "_sseg"}, sseg, exp[d]);
        end
    endtask

    initial begin
        int f;
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, {8'h9F, 8'h24, 8'h0D, 8'h99}};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h49, 8'h03}};
        vecs[2] = '{16'h00A0, 4'b1000, 1'b0, {8'h02, 8'h03, 8'hFD, 8'h03}};
        vecs[3] = '{16'h0000, 4'b0100, 1'b1, {8'hFF, 8'hFE, 8'hFF, 8'h03}};
        vecs[4] = '{16'h9876, 4'b0001, 1'b1, {8'h09, 8'h01, 8'h1F, 8'h40}};
        vecs[5] = '{16'h0F00, 4'b0000, 1'b1, {8'hFF, 8'hFD, 8'h03, 8'h03}};

        // Reset release and the first frame with all-zero digits.
        reset_dut();
        check("rst_tick", {7'h0, frame_tick}, 8'h01);
        check("rst_an", {4'h0, an}, 8'h0F);
        check("rst_sseg", sseg, 8'hFF);
        check("rst_pending", {7'h0, pending}, 8'h00);
        for (int c = 1; c <= FR; c++) begin
            int s;
            goto(c);
            s = c - 1;
            if ((s % DC) < BC) begin
                check("f0_an_blank", {4'h0, an}, 8'h0F);
                check("f0_sseg_blank", sseg, 8'hFF);
            end else begin
                check("f0_an", {4'h0, an}, {4'h0, ~(4'b0001 << ((s / DC) % 4))});
                check("f0_sseg", sseg, 8'h03);
            end
            check("f0_tick", {7'h0, frame_tick}, (c % FR == 0) ? 8'h01 : 8'h00);
        end

        // Table vectors: mid-frame load, apply at the next boundary.
        for (int v = 0; v < 6; v++) begin
            goto(next_frame() + 5);
            do_load(vecs[v].digits, vecs[v].dp, vecs[v].lz);
            check("vec_pending_set", {7'h0, pending}, 8'h01);
            f = next_frame();
            goto(f - 1);
            check("vec_pending_hold", {7'h0, pending}, 8'h01);
            goto(f);
            check("vec_tick", {7'h0, frame_tick}, 8'h01);
            tick();
            check("vec_pending_clr", {7'h0, pending}, 8'h00);
            check_frame(f, vecs[v].exp, "vec");
        end

        // Two loads in one frame: the later one wins.
        f = next_frame();
        goto(f + 3);
        do_load(16'h1111, 4'b0000, 1'b0);
        goto(f + 10);
        do_load(16'h2222, 4'b0000, 1'b0);
        check("dbl_pending", {7'h0, pending}, 8'h01);
        f = next_frame();
        goto(f + 1);
        check("dbl_pending_clr", {7'h0, pending}, 8'h00);
        check_frame(f, {8'h25, 8'h25, 8'h25, 8'h25}, "dbl");

        // Load on the boundary cycle goes straight to the display.
        f = next_frame();
        goto(f);
        do_load(16'h0009, 4'b0000, 1'b0);
        check("byp_pending", {7'h0, pending}, 8'h00);
        check_frame(f, {8'h03, 8'h03, 8'h03, 8'h09}, "byp");

        // Nibble 0xA renders as a dash.
        goto(next_frame() + 7);
        do_load(16'h000A, 4'b0000, 1'b0);
        f = next_frame();
        check_frame(f, {8'h03, 8'h03, 8'h03, 8'hFD}, "dash");

        // Asynchronous reset mid-slot while a load is pending.
        f = next_frame();
        goto(f + 3);
        do_load(16'h7777, 4'b1111, 1'b0);
        check("mid_pending", {7'h0, pending}, 8'h01);
        goto(f + 12);
        rst = 1'b1;
        #1;
        check("arst_an", {4'h0, an}, 8'h0F);
        check("arst_sseg", sseg, 8'hFF);
        check("arst_pending", {7'h0, pending}, 8'h00);
        check("arst_tick", {7'h0, frame_tick}, 8'h00);
        reset_dut();
        check("post_pending", {7'h0, pending}, 8'h00);
        check_frame(0, {8'h03, 8'h03, 8'h03, 8'h03}, "post");
        goto(FR + 1);
        check("post_pending2", {7'h0, pending}, 8'h00);
        check_frame(FR, {8'h03, 8'h03, 8'h03, 8'h03}, "post2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
